// File: rtl/jls_frame_feeder.sv
// -----------------------------------------------------------------------------
// jls_frame_feeder
// Frame sequencer placed in front of jls_encoder. Accepts a per-frame size
// command and a valid/ready pixel stream, and produces the encoder's native
// input sequence: SOF_CYCLES header cycles carrying width-1/height-1, exactly
// w*h pixel strobes, then a TAIL_CYCLES flush ending in a one-cycle o_done.
//
// Optional feature macro: JLS_FEEDER_BUBBLE_EN
//   defined   : BUBBLES idle cycles after the header and after every pixel
//   undefined : no bubble counter / GAP state, back-to-back pixels possible
//
// Ports
//   clk, rstn      clock, asynchronous active-low reset
//   i_start        one-cycle frame request (honoured in IDLE only)
//   i_w, i_h       frame width-1 / height-1, latched on accepted start
//   s_valid/s_data input pixel stream
//   s_ready        feeder accepts a pixel this cycle
//   o_sof,o_w,o_h  header strobe and size (size is 0 outside the header)
//   o_e, o_x       pixel strobe and pixel (pixel is 0 outside strobes)
//   o_busy         frame in progress
//   o_done         one-cycle pulse on the last tail cycle
//   o_err          one-cycle pulse after a start with an illegal size
// -----------------------------------------------------------------------------
module jls_frame_feeder #(
    parameter int unsigned PW          = 8,
    parameter int unsigned SOF_CYCLES  = 13,
    parameter int unsigned TAIL_CYCLES = 16,
    parameter int unsigned BUBBLES     = 0
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_start,
    input  logic [13:0]   i_w,
    input  logic [13:0]   i_h,
    input  logic          s_valid,
    input  logic [PW-1:0] s_data,
    output logic          s_ready,
    output logic          o_sof,
    output logic [13:0]   o_w,
    output logic [13:0]   o_h,
    output logic          o_e,
    output logic [PW-1:0] o_x,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err
);

    localparam int unsigned DW     = 14;
    localparam int unsigned CMAX_A = (SOF_CYCLES > TAIL_CYCLES + 1) ? SOF_CYCLES : TAIL_CYCLES + 1;
    localparam int unsigned CMAX   = (CMAX_A > BUBBLES + 1) ? CMAX_A : BUBBLES + 1;
    localparam int unsigned CW     = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
`ifdef JLS_FEEDER_BUBBLE_EN
        ST_GAP,
`endif
        ST_PIX,
        ST_TAIL
    } state_t;

    state_t        r_state, w_state_n;
    logic [CW-1:0] r_cnt,   w_cnt_n;
    logic [DW-1:0] r_col,   w_col_n;
    logic [DW-1:0] r_row,   w_row_n;
    logic [DW-1:0] r_wl,    w_wl_n;
    logic [DW-1:0] r_hl,    w_hl_n;
`ifdef JLS_FEEDER_BUBBLE_EN
    logic [CW-1:0] r_bub,   w_bub_n;
`endif

    logic          r_s_ready, w_s_ready_n;
    logic          r_sof,     w_sof_n;
    logic [DW-1:0] r_ow,      w_ow_n;
    logic [DW-1:0] r_oh,      w_oh_n;
    logic          r_e,       w_e_n;
    logic [PW-1:0] r_x,       w_x_n;
    logic          r_busy,    w_busy_n;
    logic          r_done,    w_done_n;
    logic          r_err,     w_err_n;

    // s_ready is itself the registered acceptance decision
    logic w_hs;
    assign w_hs = s_valid && r_s_ready;

    // State register and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_wl      <= '0;
            r_hl      <= '0;
`ifdef JLS_FEEDER_BUBBLE_EN
            r_bub     <= '0;
`endif
            r_s_ready <= 1'b0;
            r_sof     <= 1'b0;
            r_ow      <= '0;
            r_oh      <= '0;
            r_e       <= 1'b0;
            r_x       <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_cnt     <= w_cnt_n;
            r_col     <= w_col_n;
            r_row     <= w_row_n;
            r_wl      <= w_wl_n;
            r_hl      <= w_hl_n;
`ifdef JLS_FEEDER_BUBBLE_EN
            r_bub     <= w_bub_n;
`endif
            r_s_ready <= w_s_ready_n;
            r_sof     <= w_sof_n;
            r_ow      <= w_ow_n;
            r_oh      <= w_oh_n;
            r_e       <= w_e_n;
            r_x       <= w_x_n;
            r_busy    <= w_busy_n;
            r_done    <= w_done_n;
            r_err     <= w_err_n;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_col_n   = r_col;
        w_row_n   = r_row;
        w_wl_n    = r_wl;
        w_hl_n    = r_hl;
`ifdef JLS_FEEDER_BUBBLE_EN
        w_bub_n   = r_bub;
`endif
        w_e_n     = 1'b0;
        w_x_n     = '0;
        w_done_n  = 1'b0;
        w_err_n   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    if ((i_w >= 14'd4) && (i_h != 14'h3FFF)) begin
                        w_state_n = ST_HDR;
                        w_cnt_n   = '0;
                        w_wl_n    = i_w;
                        w_hl_n    = i_h;
                        w_col_n   = '0;
                        w_row_n   = '0;
`ifdef JLS_FEEDER_BUBBLE_EN
                        w_bub_n   = '0;
`endif
                    end else begin
                        w_err_n = 1'b1;
                    end
                end
            end
            ST_HDR: begin
                if (r_cnt == CW'(SOF_CYCLES - 1)) begin
                    w_cnt_n = '0;
`ifdef JLS_FEEDER_BUBBLE_EN
                    if (BUBBLES > 0) w_state_n = ST_GAP;
                    else             w_state_n = ST_PIX;
`else
                    w_state_n = ST_PIX;
`endif
                end else begin
                    w_cnt_n = r_cnt + CW'(1);
                end
            end
`ifdef JLS_FEEDER_BUBBLE_EN
            ST_GAP: begin
                if (r_cnt == CW'(BUBBLES - 1)) begin
                    w_cnt_n   = '0;
                    w_state_n = ST_PIX;
                end else begin
                    w_cnt_n = r_cnt + CW'(1);
                end
            end
`endif
            ST_PIX: begin
                if (w_hs) begin
                    w_e_n = 1'b1;
                    w_x_n = s_data;
`ifdef JLS_FEEDER_BUBBLE_EN
                    w_bub_n = CW'(BUBBLES);
`endif
                    // Raster walk: col wraps at w-1 into the next row
                    if (r_col == r_wl) begin
                        w_col_n = '0;
                        w_row_n = r_row + 14'd1;
                        if (r_row == r_hl) begin
                            w_state_n = ST_TAIL;
                            w_cnt_n   = '0;
                        end
                    end else begin
                        w_col_n = r_col + 14'd1;
                    end
                end
`ifdef JLS_FEEDER_BUBBLE_EN
                else if (r_bub != '0) begin
                    w_bub_n = r_bub - CW'(1);
                end
`endif
            end
            ST_TAIL: begin
                // Entry cycle carries the last pixel; TAIL_CYCLES idle cycles follow
                if (r_cnt == CW'(TAIL_CYCLES)) begin
                    w_state_n = ST_IDLE;
                end else begin
                    w_cnt_n = r_cnt + CW'(1);
                end
                w_done_n = (r_cnt == CW'(TAIL_CYCLES - 1));
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase

        // Outputs that are pure decodes of the next state
        w_sof_n  = (w_state_n == ST_HDR);
        w_ow_n   = w_sof_n ? w_wl_n : '0;
        w_oh_n   = w_sof_n ? w_hl_n : '0;
        w_busy_n = (w_state_n != ST_IDLE);
`ifdef JLS_FEEDER_BUBBLE_EN
        w_s_ready_n = (w_state_n == ST_PIX) && (w_bub_n == '0);
`else
        w_s_ready_n = (w_state_n == ST_PIX);
`endif
    end

    assign s_ready = r_s_ready;
    assign o_sof   = r_sof;
    assign o_w     = r_ow;
    assign o_h     = r_oh;
    assign o_e     = r_e;
    assign o_x     = r_x;
    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_err   = r_err;

endmodule

// File: tb/tb_jls_frame_feeder.sv
// -----------------------------------------------------------------------------
// tb_jls_frame_feeder
// Scoreboard bench: each frame command pushes its full expected event stream
// (header beats, pixels in raster order, done / err) into a queue; a monitor
// on the falling edge pops and compares whenever the DUT strobes, and also
// checks cycle relationships (latency, header contiguity, tail length).
// -----------------------------------------------------------------------------
module tb_jls_frame_feeder;

    localparam int PW   = 8;
    localparam int SOF  = 13;
    localparam int TAIL = 16;
`ifdef JLS_FEEDER_BUBBLE_EN
    localparam int BUB     = 2;
    localparam int BUB_EFF = 2;
`else
    localparam int BUB     = 0;
    localparam int BUB_EFF = 0;
`endif

    localparam int K_SOF  = 1;
    localparam int K_PIX  = 2;
    localparam int K_DONE = 3;
    localparam int K_ERR  = 4;

    typedef struct {
        int kind;
        int a;
        int b;
        int idx;
        bit last;
    } ev_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          i_start = 1'b0;
    logic [13:0]   i_w = '0;
    logic [13:0]   i_h = '0;
    logic          s_valid = 1'b0;
    logic [PW-1:0] s_data = '0;
    logic          s_ready, o_sof, o_e, o_busy, o_done, o_err;
    logic [13:0]   o_w, o_h;
    logic [PW-1:0] o_x;

    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    ev_t exp_q[$];
    bit  mode_vh = 1'b0;

    jls_frame_feeder #(
        .PW(PW), .SOF_CYCLES(SOF), .TAIL_CYCLES(TAIL), .BUBBLES(BUB)
    ) dut (
        .clk(clk), .rstn(rstn), .i_start(i_start), .i_w(i_w), .i_h(i_h),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .o_sof(o_sof), .o_w(o_w), .o_h(o_h), .o_e(o_e), .o_x(o_x),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit prev_hs = 0, prev_start = 0, prev_busy = 0, prev_ok = 0, done_next = 0;
    int since = 1000, ready_chk_cyc = -1, sof_first = 0, last_sof_cyc = 0;
    int prev_e_cyc = 0, last_e_cyc = 0;

    always @(negedge clk) begin
        int  nstr, akind;
        ev_t e;
        if (!rstn) begin
            prev_hs = 0; prev_start = 0; prev_busy = 0; prev_ok = 0;
            done_next = 0; since = 1000; ready_chk_cyc = -1;
        end else begin
            if (done_next) begin
                chk("busy_after_done", int'(o_busy), 0);
                done_next = 0;
            end
            if (prev_start) begin
                if (prev_busy) begin
                    chk("busy_start_no_sof", int'(o_sof), 0);
                    chk("busy_start_no_err", int'(o_err), 0);
                end else if (prev_ok) begin
                    chk("start_sof", int'(o_sof), 1);
                    chk("start_busy", int'(o_busy), 1);
                end else begin
                    chk("bad_start_err", int'(o_err), 1);
                    chk("bad_start_busy", int'(o_busy), 0);
                    chk("bad_start_sof", int'(o_sof), 0);
                end
            end
            if (ready_chk_cyc >= 0) begin
                if (cyc < ready_chk_cyc) chk("gap_ready_low", int'(s_ready), 0);
                else begin
                    chk("first_ready", int'(s_ready), 1);
                    ready_chk_cyc = -1;
                end
            end
            if (o_e || prev_hs) chk("pix_latency", int'(o_e), int'(prev_hs));
            if (BUB_EFF > 0 && since >= 1 && since <= BUB_EFF)
                chk("bubble_ready_low", int'(s_ready), 0);
            if (!o_sof) begin
                chk("w_zero_outside_sof", int'(o_w), 0);
                chk("h_zero_outside_sof", int'(o_h), 0);
            end
            if (!o_e) chk("x_zero_outside_e", int'(o_x), 0);

            nstr = int'(o_sof) + int'(o_e) + int'(o_done) + int'(o_err);
            if (nstr > 1) begin
                chk("strobe_overlap", nstr, 1);
            end else if (nstr == 1) begin
                akind = o_sof ? K_SOF : o_e ? K_PIX : o_done ? K_DONE : K_ERR;
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", akind, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind", akind, e.kind);
                    if (akind == e.kind) begin
                        case (akind)
                            K_SOF: begin
                                chk("sof_w", int'(o_w), e.a);
                                chk("sof_h", int'(o_h), e.b);
                                if (e.idx == 0) sof_first = cyc;
                                else chk("sof_contiguous", cyc - sof_first, e.idx);
                                if (e.idx == SOF - 1) begin
                                    last_sof_cyc  = cyc;
                                    ready_chk_cyc = cyc + BUB_EFF + 1;
                                end
                            end
                            K_PIX: begin
                                chk("pix_data", int'(o_x), e.a);
                                if (mode_vh) begin
                                    if (e.idx == 0) chk("first_pix_cycle", cyc - last_sof_cyc, BUB_EFF + 2);
                                    else chk("pix_spacing", cyc - prev_e_cyc, BUB_EFF + 1);
                                end
                                prev_e_cyc = cyc;
                                if (e.last) last_e_cyc = cyc;
                            end
                            K_DONE: begin
                                chk("done_timing", cyc - last_e_cyc, TAIL);
                                done_next = 1;
                            end
                            default: ;
                        endcase
                    end
                end
            end

            prev_hs    = s_valid && s_ready;
            since      = prev_hs ? 1 : ((since < 1000) ? since + 1 : since);
            prev_start = i_start;
            prev_busy  = o_busy;
            prev_ok    = (i_w >= 14'd4) && (i_h != 14'h3FFF);
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic recover();
        rstn = 1'b0; i_start = 1'b0; s_valid = 1'b0;
        exp_q.delete();
        tick(); tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic wait_idle(input int bound);
        bit ok = 0;
        for (int t = 0; t < bound; t++) begin
            @(negedge clk);
            if (!o_busy) begin ok = 1; break; end
        end
        if (!ok) begin
            chk("idle_timeout", 1, 0);
            recover();
        end
        tick();
    endtask

    task automatic push_ev(input int kind, input int a, input int b, input int idx, input bit last);
        ev_t e;
        e.kind = kind; e.a = a; e.b = b; e.idx = idx; e.last = last;
        exp_q.push_back(e);
    endtask

    // vmode: 0 valid held high, 1 toggling 1/0, 2 random
    task automatic run_frame(input int w1, input int h1, input int vmode,
                             input int abort_after, input bit mid_start);
        int n = (w1 + 1) * (h1 + 1);
        int pix[$];
        int k = 0;
        int budget = 8 * n + 200;
        bit tgl = 1, hs, did_mid = 0;
        wait_idle(TAIL + 50);
        for (int i = 0; i < n; i++) pix.push_back(int'($urandom_range(0, 255)));
        for (int i = 0; i < SOF; i++) push_ev(K_SOF, w1, h1, i, 0);
        for (int i = 0; i < n; i++) push_ev(K_PIX, pix[i], 0, i, i == n - 1);
        push_ev(K_DONE, 0, 0, 0, 0);
        mode_vh = (vmode == 0);
        i_start = 1'b1; i_w = 14'(w1); i_h = 14'(h1);
        tick();
        i_start = 1'b0;
        while (k < n && budget > 0) begin
            s_data = PW'(pix[k]);
            case (vmode)
                0: s_valid = 1'b1;
                1: begin s_valid = tgl; tgl = !tgl; end
                default: s_valid = 1'($urandom_range(0, 1));
            endcase
            if (mid_start && !did_mid && k == 2) begin
                i_start = 1'b1; i_w = 14'd7; i_h = 14'd0; did_mid = 1;
            end
            @(negedge clk);
            hs = s_valid && s_ready;
            tick();
            i_start = 1'b0;
            if (hs) k++;
            budget--;
            if (abort_after != 0 && k == abort_after) begin
                s_valid = 1'b0;
                @(negedge clk);
                #1;
                rstn = 1'b0;
                #1;
                chk("rst_strobes_zero", int'({s_ready, o_sof, o_e, o_busy, o_done, o_err}), 0);
                chk("rst_w_zero", int'(o_w), 0);
                chk("rst_h_zero", int'(o_h), 0);
                chk("rst_x_zero", int'(o_x), 0);
                exp_q.delete();
                tick(); tick();
                rstn = 1'b1;
                @(negedge clk);
                chk("rst_fsm_idle", int'(o_busy), 0);
                tick();
                return;
            end
        end
        if (k < n) begin
            chk("pixel_timeout", k, n);
            recover();
            return;
        end
        // Offer one more pixel: it must not be taken
        s_valid = 1'b1;
        s_data  = 8'hA5;
        @(negedge clk);
        chk("ready_drop_after_last", int'(s_ready), 0);
        tick();
        wait_idle(TAIL + 10);
        s_valid = 1'b0;
    endtask

    task automatic bad_start(input int w1, input int h1);
        wait_idle(TAIL + 50);
        push_ev(K_ERR, 0, 0, 0, 0);
        i_start = 1'b1; i_w = 14'(w1); i_h = 14'(h1);
        tick();
        i_start = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("bad_start_stays_idle", int'(o_busy), 0);
        tick();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        #3;
        chk("reset_strobes", int'({s_ready, o_sof, o_e, o_busy, o_done, o_err}), 0);
        chk("reset_w", int'(o_w), 0);
        chk("reset_h", int'(o_h), 0);
        chk("reset_x", int'(o_x), 0);
        tick(); tick();
        rstn = 1'b1;
        tick();

        run_frame(4, 1, 0, 0, 0);          // 5x2, valid held high
        run_frame(4, 1, 1, 0, 0);          // 5x2, valid toggling
        bad_start(3, 0);                   // width too small
        bad_start(4, 16383);               // height too large
        run_frame(4, 0, 0, 0, 0);          // 5x1, bubble spacing when enabled
        run_frame(5, 2, 0, 0, 1);          // start pulsed mid-PIX
        run_frame(4, 1, 0, 3, 0);          // reset after 3rd pixel
        run_frame(4, 1, 0, 0, 0);          // fresh frame after reset

        for (int r = 0; r < 6; r++) begin
            run_frame(int'($urandom_range(4, 19)), int'($urandom_range(0, 3)), 2, 0, 0);
            if ($urandom_range(0, 1) == 1) bad_start(int'($urandom_range(0, 3)), int'($urandom_range(0, 100)));
        end

        run_frame(16383, 0, 0, 0, 0);      // 16384x1

        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
